ddc_mixer: RTL and testbench



---
 rtl/ddc_mixer_pkg.sv | 19 +
 rtl/ddc_mixer_round_sat.sv | 36 +++
 rtl/ddc_mixer.sv | 131 +++++++++++++
 tb/tb_ddc_mixer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ddc_mixer_pkg.sv
// Shared types and constants for the ddc_mixer quadrature downconversion mixer.
// Dither constants are only consumed when DDC_MIXER_DITHER_EN is defined.
package ddc_mixer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_NCO = 2'd1,
    RUN      = 2'd2
  } state_t;

  // Fibonacci LFSR, taps 16,14,13,11 -> bit mask over [15:0].
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

endpackage

// File: rtl/ddc_mixer_round_sat.sv
// Per-channel output stage: optional negation, add rounding/dither word below the
// output LSB, drop the redundant sign bit and saturate to OUT_W bits.
module ddc_mixer_round_sat
  import ddc_mixer_pkg::*;
#(
  parameter int P_W   = 28,
  parameter int OUT_W = 16,
  parameter int DW    = P_W - 1 - OUT_W
) (
  input  logic signed [P_W-1:0]   product,
  input  logic                    negate,
  input  logic        [DW-1:0]    dither,
  output logic signed [OUT_W-1:0] result,
  output logic                    sat
);

  logic signed [P_W:0]     ext;
  logic signed [P_W:0]     sum;
  logic signed [OUT_W+1:0] top;
  logic                    unused_lsbs;

  // NOTE: every variable written here gets a value on every path, so no latch is inferred.
  always_comb begin
    ext    = negate ? -(P_W+1)'(product) : (P_W+1)'(product);
    sum    = ext + $signed({{(OUT_W+2){1'b0}}, dither});
    top    = sum[P_W -: OUT_W+2];
    sat    = (top[OUT_W+1:OUT_W-1] != 3'b000) && (top[OUT_W+1:OUT_W-1] != 3'b111);
    result = top[OUT_W-1:0];
    if (sat) begin
      result = top[OUT_W+1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  assign unused_lsbs = ^sum[DW-1:0];

endmodule

// File: rtl/ddc_mixer.sv
// Quadrature mixer: I = adc*cos, Q = -adc*sin, 3-stage pipeline gated by clken,
// sequenced against NCO valid. Define DDC_MIXER_DITHER_EN for LFSR dithered rounding.
module ddc_mixer
  import ddc_mixer_pkg::*;
#(
  parameter int ADC_W = 16,
  parameter int NCO_W = 12,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic                    en,
  input  logic signed [ADC_W-1:0] adc_data,
  input  logic                    adc_valid,
  input  logic signed [NCO_W-1:0] nco_sin,
  input  logic signed [NCO_W-1:0] nco_cos,
  input  logic                    nco_valid,
  output logic signed [OUT_W-1:0] i_out,
  output logic signed [OUT_W-1:0] q_out,
  output logic                    out_valid,
  output logic                    ovf_i,
  output logic                    ovf_q,
  input  logic                    ovf_clr
);

  localparam int P_W = prod_w(ADC_W, NCO_W);
  localparam int DW  = P_W - 1 - OUT_W;

  state_t state, state_nx;
  logic   accept, leave;
  logic   v0, v1;

  logic signed [ADC_W-1:0] adc_r;
  logic signed [NCO_W-1:0] cos_r, sin_r;
  logic signed [P_W-1:0]   p_i, p_q;
  logic        [DW-1:0]    dith_in, dith0, dith1;
  logic signed [OUT_W-1:0] res_i, res_q;
  logic                    sat_i, sat_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else if (clken) state <= state_nx;
  end

  // en outranks nco_valid in every state.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (en) state_nx = WAIT_NCO;
      WAIT_NCO: if (!en) state_nx = IDLE;
                else if (nco_valid) state_nx = RUN;
      RUN:      if (!en) state_nx = IDLE;
                else if (!nco_valid) state_nx = WAIT_NCO;
      default:  state_nx = IDLE;
    endcase
  end

  assign leave  = (state == RUN) && (state_nx != RUN);
  assign accept = (state == RUN) && en && adc_valid && nco_valid;

`ifdef DDC_MIXER_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr <= LFSR_SEED;
    else if (clken && accept) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign dith_in = DW'(lfsr);
`else
  assign dith_in = DW'(1) << (DW - 1);
`endif

  // NOTE: state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      out_valid <= 1'b0;
      i_out     <= '0;
      q_out     <= '0;
      ovf_i     <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (clken) begin
      v0        <= accept;
      v1        <= v0 && !leave;
      out_valid <= v1 && !leave;
      if (v1 && !leave) begin
        i_out <= res_i;
        q_out <= res_q;
      end
      ovf_i <= (ovf_i && !ovf_clr) || (v1 && !leave && sat_i);
      ovf_q <= (ovf_q && !ovf_clr) || (v1 && !leave && sat_q);
    end
  end

  // NOTE: datapath registers carry no reset; the valid bits above qualify their contents.
  always_ff @(posedge clk) begin
    if (clken) begin
      if (accept) begin
        adc_r <= adc_data;
        cos_r <= nco_cos;
        sin_r <= nco_sin;
        dith0 <= dith_in;
      end
      if (v0) begin
        p_i   <= P_W'(adc_r) * P_W'(cos_r);
        p_q   <= P_W'(adc_r) * P_W'(sin_r);
        dith1 <= dith0;
      end
    end
  end

  ddc_mixer_round_sat #(.P_W(P_W), .OUT_W(OUT_W), .DW(DW)) u_rs_i (
    .product (p_i),
    .negate  (1'b0),
    .dither  (dith1),
    .result  (res_i),
    .sat     (sat_i)
  );

  ddc_mixer_round_sat #(.P_W(P_W), .OUT_W(OUT_W), .DW(DW)) u_rs_q (
    .product (p_q),
    .negate  (1'b1),
    .dither  (dith1),
    .result  (res_q),
    .sat     (sat_q)
  );

endmodule

// File: tb/tb_ddc_mixer.sv
// Directed bench for ddc_mixer: latency, rounding, saturation, sticky flags,
// clken freeze, NCO loss-of-lock flush, en drop and async reset.
module tb_ddc_mixer;

  logic clk = 1'b0;
  logic reset_n, clken, en, adc_valid, nco_valid, ovf_clr;
  logic signed [15:0] adc_data;
  logic signed [11:0] nco_sin, nco_cos;
  logic signed [15:0] i_out, q_out;
  logic out_valid, ovf_i, ovf_q;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ddc_mixer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clken     (clken),
    .en        (en),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .nco_sin   (nco_sin),
    .nco_cos   (nco_cos),
    .nco_valid (nco_valid),
    .i_out     (i_out),
    .q_out     (q_out),
    .out_valid (out_valid),
    .ovf_i     (ovf_i),
    .ovf_q     (ovf_q),
    .ovf_clr   (ovf_clr)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] req);
    n_checks++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a, input int c, input int s);
    adc_data = 16'(a);
    nco_cos  = 12'(c);
    nco_sin  = 12'(s);
  endtask

  task automatic exp_out(input string tag, input int i, input int q);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_i"}, i_out, i);
    chk({tag, "_q"}, q_out, q);
  endtask

  initial begin
    reset_n = 1'b0; clken = 1'b1; en = 1'b0; adc_valid = 1'b0;
    nco_valid = 1'b0; ovf_clr = 1'b0;
    drive(0, 0, 0);
    #12;
    chk("rst_i", i_out, 0);
    chk("rst_q", q_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf_i", ovf_i, 0);
    chk("rst_ovf_q", ovf_q, 0);

    reset_n = 1'b1; en = 1'b1; nco_valid = 1'b1; adc_valid = 1'b1;
    drive(16384, 2047, 0);
    tick(); chk("idle_to_wait", out_valid, 0);
    tick(); chk("wait_to_run", out_valid, 0);
    tick(); chk("lat_s0", out_valid, 0);
    drive(-32768, -2048, -2048);
    tick(); chk("lat_s1", out_valid, 0);
    drive(1, 1024, 1024);
    tick(); exp_out("A", 16376, 0);
    chk("A_ovf_i", ovf_i, 0);
    chk("A_ovf_q", ovf_q, 0);
    drive(-1, 1024, 0);
    tick(); exp_out("B_sat", 32767, -32768);
    chk("B_ovf_i", ovf_i, 1);
    chk("B_ovf_q", ovf_q, 0);
    drive(1000, 0, -2048);
    ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0;
    chk("clr_ovf_i", ovf_i, 0);
    chk("C_valid", out_valid, 1);
`ifndef DDC_MIXER_DITHER_EN
    chk("C_round_i", i_out, 1);
    chk("C_round_q", q_out, 0);
`endif
    drive(2048, 1024, 0);
    tick();
`ifndef DDC_MIXER_DITHER_EN
    chk("D_round_i", i_out, 0);
    chk("D_q", q_out, 0);
`endif
    drive(-4096, 512, 512);
    tick(); exp_out("E", 0, 1000);

    clken = 1'b0;
    drive(-2048, 2047, -1024);
    tick(); exp_out("frz1", 0, 1000);
    tick(); exp_out("frz2", 0, 1000);
    clken = 1'b1;
    tick(); exp_out("F", 1024, 0);
    drive(8, 256, 256);
    tick(); exp_out("G", -1024, 1024);
    drive(16, 256, 0);
    tick(); exp_out("H", -2047, -1024);

    nco_valid = 1'b0;
    tick();
    chk("flush_valid", out_valid, 0);
    chk("flush_hold_i", i_out, -2047);
    chk("flush_hold_q", q_out, -1024);
    nco_valid = 1'b1;
    drive(-16384, 2047, 2047);
    tick(); chk("relock_wait", out_valid, 0);
    tick(); chk("relock_acc", out_valid, 0);
    tick(); chk("relock_s1", out_valid, 0);
    tick(); exp_out("K", -16376, 16376);

    en = 1'b0;
    tick();
    chk("en_off_valid", out_valid, 0);
    chk("en_off_hold_i", i_out, -16376);
    chk("en_off_hold_q", q_out, 16376);
    tick(); chk("idle_valid", out_valid, 0);
    en = 1'b1;
    drive(-32768, -2048, -2048);
    tick(); chk("re_wait", out_valid, 0);
    tick(); chk("re_run", out_valid, 0);
    tick(); chk("re_acc", out_valid, 0);
    tick(); chk("re_s1", out_valid, 0);
    tick(); exp_out("L_sat", 32767, -32768);
    chk("L_ovf_i", ovf_i, 1);

    #2 reset_n = 1'b0;
    #1;
    chk("arst_i", i_out, 0);
    chk("arst_q", q_out, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_ovf_i", ovf_i, 0);
    chk("arst_ovf_q", ovf_q, 0);
    #2;

`ifdef DDC_MIXER_DITHER_EN
    reset_n = 1'b1;
    drive(0, 2047, -2048);
    repeat (4) tick();
    for (int k = 0; k < 12; k++) begin
      tick();
      exp_out("dither_zero", 0, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
